// File: rtl/uart_tx_byte_feeder.sv
// uart_tx_byte_feeder: byte FIFO and start sequencer feeding a UART transmitter
// Buffers application bytes and issues one-cycle tx_start pulses only while the transmitter is idle.
module uart_tx_byte_feeder #(
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              flush,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    output logic [ADDR_W:0]   fifo_count,
    output logic              overrun
);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_GAP} state_e;

    state_e            state_q, state_d;
    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic              overrun_q, overrun_d;
    logic              rdy_q;
    logic              push, pop;

    // rdy_q keeps s_ready low during reset and until the first clock after release
    assign s_ready    = rdy_q & (count_q != (ADDR_W+1)'(DEPTH)) & ~flush;
    assign push       = s_valid & s_ready;
    assign pop        = (state_q == S_IDLE) & (count_q != '0) & ~tx_busy;
    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign fifo_count = count_q;
    assign overrun    = overrun_q;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= s_data;
    end

    always_comb begin
        wr_ptr_d  = flush ? '0 : wr_ptr_q + ADDR_W'(push);
        rd_ptr_d  = flush ? '0 : rd_ptr_q + ADDR_W'(pop);
        count_d   = flush ? '0 : count_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
        overrun_d = ~flush & (overrun_q | (s_valid & ~s_ready));
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        case (state_q)
            S_IDLE: state_d = pop ? S_SEND : S_IDLE;
            S_SEND: state_d = S_WAIT;
            S_WAIT: begin
                state_d = tx_busy ? S_WAIT : (GAP_CYCLES > 0 ? S_GAP : S_IDLE);
                gap_d   = tx_busy ? gap_q : GAP_W'(GAP_CYCLES);
            end
            S_GAP: begin
                gap_d   = gap_q - GAP_W'(1);
                state_d = (gap_q == GAP_W'(1)) ? S_IDLE : S_GAP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // the pop only happens on the IDLE->SEND edge, so it doubles as the start strobe
    always_comb begin
        tx_start_d = pop;
        tx_data_d  = pop ? mem_q[rd_ptr_q] : tx_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            gap_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            overrun_q  <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            gap_q      <= gap_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            overrun_q  <= overrun_d;
            rdy_q      <= 1'b1;
        end
    end
endmodule
